// File: rtl/mem_ic_pkg.sv
// Shared definitions for the N-port memory interconnect.
// Contents:
//   state_e       - transaction FSM states of the interconnect
//   ARB_RR        - ARB_MODE value selecting round-robin arbitration
//   ARB_FIXED     - ARB_MODE value selecting fixed priority (lowest index wins)
//   mask_width()  - byte-enable width for a given data width
package mem_ic_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_ISSUE = 3'd1,
      RD_WAIT  = 3'd2,
      WR_ISSUE = 3'd3,
      WR_WAIT  = 3'd4,
      RESP     = 3'd5
   } state_e;

   localparam int ARB_RR    = 0;
   localparam int ARB_FIXED = 1;

   function automatic int mask_width(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Combinational rotating-priority arbiter.
// The search starts at index ptr and wraps modulo N; the first requester
// found wins. Feeding ptr = 0 gives plain fixed priority.
// Ports:
//   req        in  N      request vector
//   ptr        in  PW     index to start the search at (must be < N)
//   grant      out N      one-hot grant, all zero when nothing requests
//   grant_idx  out PW     index of the granted requester (0 when none)
module mem_rr_arbiter #(
   parameter int N  = 2,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] grant_idx
);

   always_comb begin
      logic found;
      int   j;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      j         = 0;
      for (int k = 0; k < N; k++) begin
         // Wrap the candidate index without a modulo operator so that
         // non-power-of-two N stays cheap.
         j = int'(ptr) + k;
         if (j >= N) begin
            j = j - N;
         end
         if (!found && req[j]) begin
            found     = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = PW'(j);
         end
      end
   end

endmodule

// File: rtl/mem_interconnect_nport.sv
// N-master, single-port memory interconnect.
// Arbitrates level-held read/write requests from NUM_MASTERS ports onto one
// main-memory port using the mem_* strobe/busy protocol. One transaction is
// in flight at a time; every output is registered.
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   m_addr/m_wdata/m_wmask  per-master request fields, master i at slice i
//   m_wen/m_ren             per-master write/read requests, held until m_ready
//   m_rdata                 shared read data, valid with m_ready
//   m_ready                 one-hot, one-cycle completion pulse
//   mem_addr/mem_wdata      memory address/write data, stable through RESP
//   mem_wmask               one-cycle write strobe (nonzero byte mask)
//   mem_rstrb               one-cycle read strobe
//   mem_rdata               memory read data
//   mem_rbusy/mem_wbusy     memory busy flags
//   busy                    high whenever the FSM is not in IDLE
module mem_interconnect_nport
   import mem_ic_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int ARB_MODE    = 0
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_MASTERS*ADDR_W-1:0]        m_addr,
   input  logic [NUM_MASTERS*DATA_W-1:0]        m_wdata,
   input  logic [NUM_MASTERS*(DATA_W/8)-1:0]    m_wmask,
   input  logic [NUM_MASTERS-1:0]               m_wen,
   input  logic [NUM_MASTERS-1:0]               m_ren,
   output logic [DATA_W-1:0]                    m_rdata,
   output logic [NUM_MASTERS-1:0]               m_ready,
   output logic [ADDR_W-1:0]                    mem_addr,
   output logic [DATA_W-1:0]                    mem_wdata,
   output logic [(DATA_W/8)-1:0]                mem_wmask,
   output logic                                 mem_rstrb,
   input  logic [DATA_W-1:0]                    mem_rdata,
   input  logic                                 mem_rbusy,
   input  logic                                 mem_wbusy,
   output logic                                 busy
);

   localparam int MASK_W = mask_width(DATA_W);
   localparam int PTR_W  = $clog2(NUM_MASTERS);

   state_e                   state_q, state_d;
   logic [PTR_W-1:0]         ptr_q, ptr_d;
   logic [NUM_MASTERS-1:0]   grant_q, grant_d;
   logic [ADDR_W-1:0]        addr_q, addr_d;
   logic [DATA_W-1:0]        wdata_q, wdata_d;
   logic [MASK_W-1:0]        mask_q, mask_d;
   logic [MASK_W-1:0]        wmask_out_q, wmask_out_d;
   logic                     rstrb_q, rstrb_d;
   logic [NUM_MASTERS-1:0]   ready_q, ready_d;
   logic [DATA_W-1:0]        rdata_q, rdata_d;
   logic                     busy_q, busy_d;

   logic [NUM_MASTERS-1:0]   req;
   logic [PTR_W-1:0]         arb_ptr;
   logic [NUM_MASTERS-1:0]   arb_grant;
   logic [PTR_W-1:0]         arb_idx;

   assign req = m_wen | m_ren;

   // Fixed priority is round-robin with the search pinned to index 0.
   assign arb_ptr = (ARB_MODE == ARB_FIXED) ? '0 : ptr_q;

   mem_rr_arbiter #(
      .N  (NUM_MASTERS),
      .PW (PTR_W)
   ) u_arb (
      .req       (req),
      .ptr       (arb_ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx)
   );

   // Next-state logic. Strobes and m_ready are computed for the state being
   // entered so that, once registered, they line up with that state.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      grant_d     = grant_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      mask_d      = mask_q;
      wmask_out_d = '0;
      rstrb_d     = 1'b0;
      ready_d     = '0;
      rdata_d     = rdata_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               grant_d = arb_grant;
               ptr_d   = (arb_idx == PTR_W'(NUM_MASTERS - 1)) ? '0 : arb_idx + PTR_W'(1);
               addr_d  = m_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
               wdata_d = m_wdata[int'(arb_idx)*DATA_W +: DATA_W];
               mask_d  = m_wmask[int'(arb_idx)*MASK_W +: MASK_W];
               // A write wins over a simultaneous read from the same master;
               // an empty byte mask completes without touching memory.
               if (m_wen[arb_idx]) begin
                  if (mask_d == '0) begin
                     state_d = RESP;
                     ready_d = arb_grant;
                  end else begin
                     state_d     = WR_ISSUE;
                     wmask_out_d = mask_d;
                  end
               end else begin
                  state_d = RD_ISSUE;
                  rstrb_d = 1'b1;
               end
            end
         end
         RD_ISSUE: state_d = RD_WAIT;
         RD_WAIT: begin
            if (!mem_rbusy) begin
               rdata_d = mem_rdata;
               state_d = RESP;
               ready_d = grant_q;
            end
         end
         WR_ISSUE: state_d = WR_WAIT;
         WR_WAIT: begin
            if (!mem_wbusy) begin
               state_d = RESP;
               ready_d = grant_q;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset abandons any in-flight access.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         grant_q     <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         mask_q      <= '0;
         wmask_out_q <= '0;
         rstrb_q     <= 1'b0;
         ready_q     <= '0;
         rdata_q     <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         grant_q     <= grant_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         mask_q      <= mask_d;
         wmask_out_q <= wmask_out_d;
         rstrb_q     <= rstrb_d;
         ready_q     <= ready_d;
         rdata_q     <= rdata_d;
         busy_q      <= busy_d;
      end
   end

   assign m_rdata   = rdata_q;
   assign m_ready   = ready_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wmask = wmask_out_q;
   assign mem_rstrb = rstrb_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_interconnect_nport.sv
// Directed testbench for mem_interconnect_nport with four masters.
// Two instances share all inputs: u_rr uses round-robin, u_fx fixed priority.
module tb_mem_interconnect_nport;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = DW / 8;

   logic              clk;
   logic              reset;
   logic [N*AW-1:0]   m_addr;
   logic [N*DW-1:0]   m_wdata;
   logic [N*MW-1:0]   m_wmask;
   logic [N-1:0]      m_wen;
   logic [N-1:0]      m_ren;
   logic [DW-1:0]     mem_rdata;
   logic              mem_rbusy;
   logic              mem_wbusy;

   logic [DW-1:0]     rr_rdata,  fx_rdata;
   logic [N-1:0]      rr_ready,  fx_ready;
   logic [AW-1:0]     rr_addr,   fx_addr;
   logic [DW-1:0]     rr_wdata,  fx_wdata;
   logic [MW-1:0]     rr_wmask,  fx_wmask;
   logic              rr_rstrb,  fx_rstrb;
   logic              rr_busy,   fx_busy;

   int vectors;
   int miscompares;

   mem_interconnect_nport #(
      .NUM_MASTERS (N), .ADDR_W (AW), .DATA_W (DW), .ARB_MODE (0)
   ) u_rr (
      .clk (clk), .reset (reset),
      .m_addr (m_addr), .m_wdata (m_wdata), .m_wmask (m_wmask),
      .m_wen (m_wen), .m_ren (m_ren),
      .m_rdata (rr_rdata), .m_ready (rr_ready),
      .mem_addr (rr_addr), .mem_wdata (rr_wdata), .mem_wmask (rr_wmask),
      .mem_rstrb (rr_rstrb), .mem_rdata (mem_rdata),
      .mem_rbusy (mem_rbusy), .mem_wbusy (mem_wbusy), .busy (rr_busy)
   );

   mem_interconnect_nport #(
      .NUM_MASTERS (N), .ADDR_W (AW), .DATA_W (DW), .ARB_MODE (1)
   ) u_fx (
      .clk (clk), .reset (reset),
      .m_addr (m_addr), .m_wdata (m_wdata), .m_wmask (m_wmask),
      .m_wen (m_wen), .m_ren (m_ren),
      .m_rdata (fx_rdata), .m_ready (fx_ready),
      .mem_addr (fx_addr), .mem_wdata (fx_wdata), .mem_wmask (fx_wmask),
      .mem_rstrb (fx_rstrb), .mem_rdata (mem_rdata),
      .mem_rbusy (mem_rbusy), .mem_wbusy (mem_wbusy), .busy (fx_busy)
   );

   // 100 MHz free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence gets stuck
   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one rising edge and settle just after it
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // One comparison point
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Directed sequence with hand-computed expectations
   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      m_addr      = '0;
      m_wdata     = '0;
      m_wmask     = '0;
      m_wen       = '0;
      m_ren       = '0;
      mem_rdata   = '0;
      mem_rbusy   = 1'b0;
      mem_wbusy   = 1'b0;

      // Reset values
      #3;
      checkOutput("rst_ready", {60'd0, rr_ready}, 64'h0);
      checkOutput("rst_busy",  {63'd0, rr_busy},  64'h0);
      checkOutput("rst_addr",  {32'd0, rr_addr},  64'h0);
      checkOutput("rst_rstrb", {63'd0, rr_rstrb}, 64'h0);
      applyStimulus();
      applyStimulus();
      reset = 1'b1;
      applyStimulus();

      // Single read from master 1, memory responds immediately
      m_addr[1*AW +: AW] = 32'h0000_0100;
      mem_rdata          = 32'hDEAD_BEEF;
      m_ren              = 4'b0010;
      applyStimulus();
      checkOutput("rd_rstrb_t1", {63'd0, rr_rstrb}, 64'h1);
      checkOutput("rd_addr_t1",  {32'd0, rr_addr},  64'h100);
      checkOutput("rd_busy_t1",  {63'd0, rr_busy},  64'h1);
      checkOutput("rd_ready_t1", {60'd0, rr_ready}, 64'h0);
      applyStimulus();
      checkOutput("rd_rstrb_t2", {63'd0, rr_rstrb}, 64'h0);
      checkOutput("rd_ready_t2", {60'd0, rr_ready}, 64'h0);
      applyStimulus();
      checkOutput("rd_ready_t3", {60'd0, rr_ready}, 64'h2);
      checkOutput("rd_rdata_t3", {32'd0, rr_rdata}, 64'hDEAD_BEEF);
      checkOutput("rd_ready_fx", {60'd0, fx_ready}, 64'h2);
      m_ren = '0;
      applyStimulus();
      checkOutput("rd_ready_t4", {60'd0, rr_ready}, 64'h0);
      checkOutput("rd_busy_t4",  {63'd0, rr_busy},  64'h0);
      checkOutput("rd_rdata_hold", {32'd0, rr_rdata}, 64'hDEAD_BEEF);

      // Write from master 0 with three busy cycles
      m_addr[0*AW +: AW]  = 32'h0000_0200;
      m_wdata[0*DW +: DW] = 32'h1234_5678;
      m_wmask[0*MW +: MW] = 4'hF;
      m_wen               = 4'b0001;
      applyStimulus();
      checkOutput("wr_wmask_t1", {60'd0, rr_wmask}, 64'hF);
      checkOutput("wr_addr_t1",  {32'd0, rr_addr},  64'h200);
      checkOutput("wr_wdata_t1", {32'd0, rr_wdata}, 64'h1234_5678);
      checkOutput("wr_rstrb_t1", {63'd0, rr_rstrb}, 64'h0);
      mem_wbusy = 1'b1;
      applyStimulus();
      checkOutput("wr_wmask_t2", {60'd0, rr_wmask}, 64'h0);
      checkOutput("wr_addr_t2",  {32'd0, rr_addr},  64'h200);
      applyStimulus();
      checkOutput("wr_ready_t3", {60'd0, rr_ready}, 64'h0);
      applyStimulus();
      checkOutput("wr_ready_t4", {60'd0, rr_ready}, 64'h0);
      mem_wbusy = 1'b0;
      applyStimulus();
      checkOutput("wr_ready_t5", {60'd0, rr_ready}, 64'h1);
      checkOutput("wr_wdata_t5", {32'd0, rr_wdata}, 64'h1234_5678);
      checkOutput("wr_addr_t5",  {32'd0, rr_addr},  64'h200);
      m_wen = '0;
      applyStimulus();
      checkOutput("wr_ready_t6", {60'd0, rr_ready}, 64'h0);
      checkOutput("wr_busy_t6",  {63'd0, rr_busy},  64'h0);

      // Master 2 asks for write and read together: only the write happens
      m_addr[2*AW +: AW]  = 32'h0000_0300;
      m_wdata[2*DW +: DW] = 32'hCAFE_0002;
      m_wmask[2*MW +: MW] = 4'h3;
      m_wen               = 4'b0100;
      m_ren               = 4'b0100;
      applyStimulus();
      checkOutput("wr_rd_wmask", {60'd0, rr_wmask}, 64'h3);
      checkOutput("wr_rd_rstrb1", {63'd0, rr_rstrb}, 64'h0);
      checkOutput("wr_rd_addr", {32'd0, rr_addr}, 64'h300);
      applyStimulus();
      checkOutput("wr_rd_rstrb2", {63'd0, rr_rstrb}, 64'h0);
      applyStimulus();
      checkOutput("wr_rd_ready", {60'd0, rr_ready}, 64'h4);
      checkOutput("wr_rd_rstrb3", {63'd0, rr_rstrb}, 64'h0);
      m_wen = '0;
      m_ren = '0;
      applyStimulus();
      checkOutput("wr_rd_ready_off", {60'd0, rr_ready}, 64'h0);

      // Zero-mask write from master 3 completes without a memory access
      m_wmask[3*MW +: MW] = 4'h0;
      m_wen               = 4'b1000;
      applyStimulus();
      checkOutput("zm_ready", {60'd0, rr_ready}, 64'h8);
      checkOutput("zm_wmask", {60'd0, rr_wmask}, 64'h0);
      checkOutput("zm_rstrb", {63'd0, rr_rstrb}, 64'h0);
      checkOutput("zm_busy",  {63'd0, rr_busy},  64'h1);
      m_wen = '0;
      applyStimulus();
      checkOutput("zm_ready_off", {60'd0, rr_ready}, 64'h0);
      checkOutput("zm_busy_off",  {63'd0, rr_busy},  64'h0);

      // All four masters read continuously. Previous grants (1,0,2,3) leave
      // the round-robin pointer at 0, so the order is 0,1,2,3,0; fixed
      // priority serves master 0 every time.
      for (int i = 0; i < N; i++) begin
         m_addr[i*AW +: AW] = 32'h1000 + 32'(i);
      end
      m_ren = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         logic [3:0] exp_rr;
         int         n;
         exp_rr = 4'b0001 << (t % 4);
         n      = 0;
         do begin
            applyStimulus();
            n++;
         end while (rr_ready == '0 && n < 10);
         checkOutput($sformatf("rr_grant_%0d", t), {60'd0, rr_ready}, {60'd0, exp_rr});
         checkOutput($sformatf("fx_grant_%0d", t), {60'd0, fx_ready}, 64'h1);
      end
      m_ren = '0;
      applyStimulus();
      applyStimulus();
      checkOutput("arb_idle_busy", {63'd0, rr_busy}, 64'h0);

      // Reset while waiting on memory read data
      mem_rdata = 32'h5555_AAAA;
      mem_rbusy = 1'b1;
      m_ren     = 4'b0010;
      applyStimulus();
      applyStimulus();
      checkOutput("rw_busy_pre", {63'd0, rr_busy}, 64'h1);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("rw_ready", {60'd0, rr_ready}, 64'h0);
      checkOutput("rw_rdata", {32'd0, rr_rdata}, 64'h0);
      checkOutput("rw_addr",  {32'd0, rr_addr},  64'h0);
      checkOutput("rw_wdata", {32'd0, rr_wdata}, 64'h0);
      checkOutput("rw_busy",  {63'd0, rr_busy},  64'h0);
      checkOutput("rw_rstrb", {63'd0, rr_rstrb}, 64'h0);
      m_ren     = '0;
      mem_rbusy = 1'b0;
      applyStimulus();
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         applyStimulus();
         checkOutput($sformatf("post_rst_ready_%0d", c), {60'd0, rr_ready}, 64'h0);
         checkOutput($sformatf("post_rst_busy_%0d", c),  {63'd0, rr_busy},  64'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
